mc_ctrl_fsm: RTL and testbench

- Next-generation multicycle control unit for the MIPS core.
- Sequences Fetch/Decode/Execute/Memory/Writeback over a shared memory port with a ready handshake (variable-latency memory) instead of fixed one-cycle access.
- Adds a parametrised wait-timeout counter, a sticky Halt state for illegal opcodes and faults, and a retire pulse.
- Drives the multicycle datapath select, enable and ALU-op signals.

---
 rtl/mc_ctrl_fsm.sv | 234 +++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS control unit with variable-latency memory
// handshake, wait timeout, and a sticky Halt state for illegal opcodes and faults.
// Ports: clk, rst_n (async active-low), opcode, alu_zero, mem_ready in;
// datapath enables/selects, alu_op, state, retire, illegal, mem_fault out.
// Optional macro MC_CTRL_BNE_EN: BNE (000101) branches on ~alu_zero.
module mc_ctrl_fsm #(
   parameter int WAIT_MAX = 16,
   parameter int CNT_W    = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       alu_zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       ir_wr,
   output logic       mem_req,
   output logic       mem_we,
   output logic       mem_addr_sel,
   output logic       alu_srca_sel,
   output logic [1:0] alu_srcb_sel,
   output logic [3:0] alu_op,
   output logic       reg_we,
   output logic       wreg_dst_sel,
   output logic       wrbck_data_sel,
   output logic [1:0] nxt_pc_sel,
   output logic [3:0] state,
   output logic       retire,
   output logic       illegal,
   output logic       mem_fault
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MADDR  = 4'd2,
      S_MRD    = 4'd3,  S_MWB    = 4'd4,  S_MWR    = 4'd5,
      S_RREX   = 4'd6,  S_RRWB   = 4'd7,  S_BEQ    = 4'd8,
      S_JMP    = 4'd9,  S_RIEX   = 4'd10, S_RIWB   = 4'd11,
      S_HALT   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RR    = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [3:0] A_ADD  = 4'd0;
   localparam logic [3:0] A_SUB  = 4'd1;
   localparam logic [3:0] A_ADDU = 4'd2;
   localparam logic [3:0] A_AND  = 4'd3;
   localparam logic [3:0] A_OR   = 4'd4;
   localparam logic [3:0] A_XOR  = 4'd5;
   localparam logic [3:0] A_RR   = 4'd6;

   localparam int             LIM   = (WAIT_MAX > 0) ? WAIT_MAX - 1 : 0;
   localparam logic [CNT_W-1:0] LIM_C = CNT_W'(LIM);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ill_q, ill_d;
   logic             flt_q, flt_d;
   logic             wait_st, timeout;

   assign wait_st = (state_q == S_FETCH) || (state_q == S_MRD) ||
                    (state_q == S_MWR);
   // ready on the limit cycle completes the access instead of faulting
   assign timeout = (WAIT_MAX > 0) && wait_st && !mem_ready &&
                    (cnt_q == LIM_C);

   always_comb begin
      state_d = state_q;
      ill_d   = ill_q;
      flt_d   = flt_q;
      unique case (state_q)
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            unique case (opcode)
               OP_LW, OP_SW: state_d = S_MADDR;
               OP_RR:        state_d = S_RREX;
               OP_BEQ:       state_d = S_BEQ;
`ifdef MC_CTRL_BNE_EN
               OP_BNE:       state_d = S_BEQ;
`endif
               OP_J:         state_d = S_JMP;
               OP_ADDI, OP_ADDIU, OP_ANDI,
               OP_ORI, OP_XORI: state_d = S_RIEX;
               default: begin
                  state_d = S_HALT;
                  ill_d   = 1'b1;
               end
            endcase
         end
         S_MADDR:  state_d = (opcode == OP_SW) ? S_MWR : S_MRD;
         S_MRD:    if (mem_ready) state_d = S_MWB;
         S_MWR:    if (mem_ready) state_d = S_FETCH;
         S_RREX:   state_d = S_RRWB;
         S_RIEX:   state_d = S_RIWB;
         S_MWB, S_RRWB, S_BEQ, S_JMP, S_RIWB: state_d = S_FETCH;
         default:  state_d = S_HALT;
      endcase
      if (timeout) begin
         state_d = S_HALT;
         flt_d   = 1'b1;
      end

      cnt_d = cnt_q;
      if (wait_st && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      // fresh count on entering a wait state or completing an access
      if (mem_ready) cnt_d = '0;
      if (state_d != state_q &&
          (state_d == S_FETCH || state_d == S_MRD || state_d == S_MWR))
         cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
         ill_q   <= 1'b0;
         flt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ill_q   <= ill_d;
         flt_q   <= flt_d;
      end
   end

   logic pc_en_c, ir_wr_c, req_c, we_c, reg_we_c, ret_c;

   always_comb begin
      pc_en_c        = 1'b0;
      ir_wr_c        = 1'b0;
      req_c          = 1'b0;
      we_c           = 1'b0;
      reg_we_c       = 1'b0;
      ret_c          = 1'b0;
      mem_addr_sel   = 1'b0;
      alu_srca_sel   = 1'b0;
      alu_srcb_sel   = 2'd0;
      alu_op         = A_ADD;
      wreg_dst_sel   = 1'b0;
      wrbck_data_sel = 1'b0;
      nxt_pc_sel     = 2'd0;
      unique case (state_q)
         S_FETCH: begin
            req_c        = 1'b1;
            alu_srcb_sel = 2'd1;
            ir_wr_c      = mem_ready;
            pc_en_c      = mem_ready;
         end
         S_DECODE: alu_srcb_sel = 2'd3;
         S_MADDR: begin
            alu_srca_sel = 1'b1;
            alu_srcb_sel = 2'd2;
         end
         S_MRD: begin
            req_c        = 1'b1;
            mem_addr_sel = 1'b1;
         end
         S_MWB: begin
            reg_we_c       = 1'b1;
            wrbck_data_sel = 1'b1;
            ret_c          = 1'b1;
         end
         S_MWR: begin
            req_c        = 1'b1;
            we_c         = 1'b1;
            mem_addr_sel = 1'b1;
            ret_c        = mem_ready;
         end
         S_RREX: begin
            alu_srca_sel = 1'b1;
            alu_op       = A_RR;
         end
         S_RRWB: begin
            reg_we_c     = 1'b1;
            wreg_dst_sel = 1'b1;
            ret_c        = 1'b1;
         end
         S_BEQ: begin
            alu_srca_sel = 1'b1;
            alu_op       = A_SUB;
            nxt_pc_sel   = 2'd1;
            ret_c        = 1'b1;
`ifdef MC_CTRL_BNE_EN
            pc_en_c = (opcode == OP_BNE) ? !alu_zero : alu_zero;
`else
            pc_en_c = alu_zero;
`endif
         end
         S_JMP: begin
            pc_en_c    = 1'b1;
            nxt_pc_sel = 2'd2;
            ret_c      = 1'b1;
         end
         S_RIEX: begin
            alu_srca_sel = 1'b1;
            alu_srcb_sel = 2'd2;
            unique case (opcode)
               OP_ADDIU: alu_op = A_ADDU;
               OP_ANDI:  alu_op = A_AND;
               OP_ORI:   alu_op = A_OR;
               OP_XORI:  alu_op = A_XOR;
               default:  alu_op = A_ADD;
            endcase
         end
         S_RIWB: begin
            reg_we_c = 1'b1;
            ret_c    = 1'b1;
         end
         default: ;
      endcase
   end

   // enables held low while reset is asserted so nothing is written
   assign pc_en     = pc_en_c  & rst_n;
   assign ir_wr     = ir_wr_c  & rst_n;
   assign mem_req   = req_c    & rst_n;
   assign mem_we    = we_c     & rst_n;
   assign reg_we    = reg_we_c & rst_n;
   assign retire    = ret_c    & rst_n;
   assign state     = state_q;
   assign illegal   = ill_q;
   assign mem_fault = flt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: randomized instruction-level scoreboard bench for mc_ctrl_fsm.
// Driver pushes per-cycle expectations; a negedge monitor pops and compares.
module tb_mc_ctrl_fsm;

   localparam int WM = 4;

   typedef struct packed {
      logic [3:0] st;
      logic       pc_en, ir_wr, mem_req, mem_we, asel, srca;
      logic [1:0] srcb;
      logic [3:0] alu;
      logic       reg_we, dst, wb;
      logic [1:0] nxt;
      logic       ret, ill, flt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       alu_zero, mem_ready;
   logic       pc_en, ir_wr, mem_req, mem_we, mem_addr_sel, alu_srca_sel;
   logic [1:0] alu_srcb_sel, nxt_pc_sel;
   logic [3:0] alu_op, state;
   logic       reg_we, wreg_dst_sel, wrbck_data_sel, retire, illegal, mem_fault;

   mc_ctrl_fsm #(.WAIT_MAX(WM)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero),
      .mem_ready(mem_ready), .pc_en(pc_en), .ir_wr(ir_wr),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
      .alu_srca_sel(alu_srca_sel), .alu_srcb_sel(alu_srcb_sel),
      .alu_op(alu_op), .reg_we(reg_we), .wreg_dst_sel(wreg_dst_sel),
      .wrbck_data_sel(wrbck_data_sel), .nxt_pc_sel(nxt_pc_sel),
      .state(state), .retire(retire), .illegal(illegal),
      .mem_fault(mem_fault)
   );

   always #5 clk = ~clk;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   ill_m, flt_m;

`ifdef MC_CTRL_BNE_EN
   localparam bit BNE_ON = 1'b1;
`else
   localparam bit BNE_ON = 1'b0;
`endif

   function automatic bit is_legal(logic [5:0] op);
      if (op == 6'b000101) return BNE_ON;
      return op inside {6'b000000, 6'b000010, 6'b000100, 6'b001000,
                        6'b001001, 6'b001100, 6'b001101, 6'b001110,
                        6'b100011, 6'b101011};
   endfunction

   // expected outputs of one cycle, straight from the state table
   function automatic exp_t row(int st, bit rdy, bit z, logic [5:0] op,
                                bit rst);
      exp_t e;
      e = '0;
      e.st  = 4'(st);
      e.ill = ill_m;
      e.flt = flt_m;
      case (st)
         0: begin
            e.mem_req = 1; e.srcb = 1; e.ir_wr = rdy; e.pc_en = rdy;
         end
         1: e.srcb = 3;
         2: begin e.srca = 1; e.srcb = 2; end
         3: begin e.mem_req = 1; e.asel = 1; end
         4: begin e.reg_we = 1; e.wb = 1; e.ret = 1; end
         5: begin
            e.mem_req = 1; e.mem_we = 1; e.asel = 1; e.ret = rdy;
         end
         6: begin e.srca = 1; e.alu = 6; end
         7: begin e.reg_we = 1; e.dst = 1; e.ret = 1; end
         8: begin
            e.srca = 1; e.alu = 1; e.nxt = 1; e.ret = 1;
            e.pc_en = (op == 6'b000101) ? !z : z;
         end
         9: begin e.pc_en = 1; e.nxt = 2; e.ret = 1; end
         10: begin
            e.srca = 1; e.srcb = 2;
            case (op)
               6'b001001: e.alu = 2;
               6'b001100: e.alu = 3;
               6'b001101: e.alu = 4;
               6'b001110: e.alu = 5;
               default:   e.alu = 0;
            endcase
         end
         11: begin e.reg_we = 1; e.ret = 1; end
         default: ;
      endcase
      if (rst) begin
         e.pc_en = 0; e.ir_wr = 0; e.mem_req = 0;
         e.mem_we = 0; e.reg_we = 0; e.ret = 0;
      end
      return e;
   endfunction

   task automatic step(int st, bit rdy, bit z);
      mem_ready = rdy;
      alu_zero  = z;
      q.push_back(row(st, rdy, z, opcode, 1'b0));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      ill_m     = 0;
      flt_m     = 0;
      mem_ready = 1'($urandom);
      q.push_back(row(0, mem_ready, alu_zero, opcode, 1'b1));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic halt_tail();
      for (int i = 0; i < 3; i++) begin
         opcode = 6'($urandom);
         step(12, 1'($urandom), 1'($urandom));
      end
      do_reset();
   endtask

   // one instruction: fw / mw = not-ready cycles in Fetch / memory stage
   task automatic run(logic [5:0] op, int fw, int mw, bit z);
      opcode = op;
      for (int i = 0; i < fw && i < WM; i++) step(0, 0, 1'($urandom));
      if (fw >= WM) begin
         flt_m = 1;
         halt_tail();
         return;
      end
      step(0, 1, 1'($urandom));
      step(1, 1'($urandom), 1'($urandom));
      if (!is_legal(op)) begin
         ill_m = 1;
         halt_tail();
         return;
      end
      case (op)
         6'b100011, 6'b101011: begin
            step(2, 1'($urandom), 1'($urandom));
            for (int i = 0; i < mw && i < WM; i++)
               step(op == 6'b101011 ? 5 : 3, 0, 1'($urandom));
            if (mw >= WM) begin
               flt_m = 1;
               halt_tail();
               return;
            end
            if (op == 6'b101011) step(5, 1, 1'($urandom));
            else begin
               step(3, 1, 1'($urandom));
               step(4, 1'($urandom), 1'($urandom));
            end
         end
         6'b000000: begin
            step(6, 1'($urandom), 1'($urandom));
            step(7, 1'($urandom), 1'($urandom));
         end
         6'b000100, 6'b000101: step(8, 1'($urandom), z);
         6'b000010: step(9, 1'($urandom), 1'($urandom));
         default: begin
            step(10, 1'($urandom), 1'($urandom));
            step(11, 1'($urandom), 1'($urandom));
         end
      endcase
   endtask

   initial begin : monitor
      exp_t e, a;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            a = {state, pc_en, ir_wr, mem_req, mem_we, mem_addr_sel,
                 alu_srca_sel, alu_srcb_sel, alu_op, reg_we, wreg_dst_sel,
                 wrbck_data_sel, nxt_pc_sel, retire, illegal, mem_fault};
            n_cmp++;
            if (a !== e) begin
               n_bad++;
               $display("FAIL cycle_out st=%0d t=%0t: got %h want %h",
                        e.st, $time, a, e);
            end
         end
      end
   end

   logic [5:0] ops [12] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                            6'b000010, 6'b001000, 6'b001001, 6'b001100,
                            6'b001101, 6'b001110, 6'b000101, 6'b111111};

   initial begin
      logic [5:0] op;
      int fw, mw;
      rst_n = 1'b0; opcode = '0; alu_zero = 0; mem_ready = 0;
      @(posedge clk);
      #1;
      do_reset();
      run(6'b000000, 0, 0, 0);
      run(6'b100011, 0, 3, 0);
      run(6'b000100, 1, 0, 0);
      run(6'b000100, 0, 0, 1);
      run(6'b000010, 2, 0, 0);
      run(6'b000000, WM - 1, 0, 0);
      run(6'b001101, WM, 0, 0);
      run(6'b111111, 0, 0, 0);
      run(6'b000101, 0, 0, 0);
      run(6'b101011, 0, 2, 0);
      run(6'b100011, 0, WM, 0);
      // abandon a store mid-wait: no write may leak during reset
      opcode = 6'b101011;
      step(0, 1, 0); step(1, 0, 0); step(2, 0, 0); step(5, 0, 0);
      do_reset();
      for (int n = 0; n < 300; n++) begin
         op = ops[$urandom_range(0, 11)];
         if (op == 6'b111111) op = 6'($urandom);
         fw = ($urandom_range(0, 15) == 0) ? WM : $urandom_range(0, WM - 1);
         mw = ($urandom_range(0, 15) == 0) ? WM : $urandom_range(0, WM - 1);
         run(op, fw, mw, 1'($urandom));
      end
      repeat (2) @(posedge clk);
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
